// File: rtl/checksum_ctrl.sv
// Byte-serial 16-bit one's-complement checksum controller: pairs bytes big-endian,
// accumulates with end-around carry, and holds the result until the consumer takes it.
module checksum_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      checksum,
    output logic             sum_ok,
    output logic [1:0]       fsm_state
);

    // Handshakes: a byte moves on any rising edge where in_valid && in_ready;
    // the result moves on any rising edge where res_valid && res_ready, and
    // res_valid/checksum/sum_ok stay put until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      sum;
    logic [7:0]       hi_reg;
    logic [LEN_W-1:0] remaining;
    logic             phase;

    logic             last_byte;
    logic [15:0]      word;
    logic [15:0]      sum_next;

    // 17-bit add with one end-around fold; a second carry cannot arise because
    // the folded value is at most 16'hFFFF.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] raw;
        raw = {1'b0, a} + {1'b0, b};
        return raw[15:0] + {15'd0, raw[16]};
    endfunction

    always_comb begin
        last_byte = (remaining == LEN_W'(1));
        word      = 16'h0000;
        if (phase) begin
            word = {hi_reg, in_data};
        end else if (last_byte) begin
            word = {in_data, 8'h00};
        end
        sum_next = ones_add(sum, word);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sum       <= 16'h0000;
            hi_reg    <= 8'h00;
            remaining <= '0;
            phase     <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= cfg_len;
                        sum       <= 16'h0000;
                        phase     <= 1'b0;
                        busy      <= 1'b1;
                        if (cfg_len != '0) begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end
                    end
                end

                ACCUM: begin
                    if (in_valid && in_ready) begin
                        remaining <= remaining - LEN_W'(1);
                        if (!phase && !last_byte) begin
                            hi_reg <= in_data;
                            phase  <= 1'b1;
                        end else begin
                            sum   <= sum_next;
                            phase <= 1'b0;
                        end
                        if (last_byte) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign checksum  = ~sum;
    assign sum_ok    = (sum == 16'hFFFF);
    assign fsm_state = state;

endmodule

// File: tb/tb_checksum_ctrl.sv
// Directed bench for checksum_ctrl: table of frames with hand-computed checksums,
// plus hand-written reset-mid-frame and backpressure sequences.
module tb_checksum_ctrl;

    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      checksum;
    logic             sum_ok;
    logic [1:0]       fsm_state;

    checksum_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .checksum  (checksum),
        .sum_ok    (sum_ok),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    logic        exp_ok_q[$];

    typedef struct {
        string       name;
        int          len;
        logic [63:0] data;    // byte 0 in bits 63:56
        int          gap;     // idle cycles before every byte
        int          hold;    // cycles res_ready stays low in DONE
        logic [15:0] exp_cks;
        logic        exp_ok;
    } frame_t;

    frame_t vec[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: one whole frame, result checked against the scoreboard queue
    task automatic run_frame(input frame_t f);
        int t0;
        int waited;
        logic [15:0] exp_cks;
        logic        exp_ok;
        logic [15:0] held;
        exp_q.push_back(f.exp_cks);
        exp_ok_q.push_back(f.exp_ok);
        @(negedge clk);
        chk({f.name, " idle busy"}, busy, 0);
        start   = 1'b1;
        cfg_len = LEN_W'(f.len);
        t0      = cyc;
        @(negedge clk);
        start   = 1'b0;
        cfg_len = '0;
        for (int i = 0; i < f.len; i++) begin
            for (int g = 0; g < f.gap; g++) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                chk({f.name, " in_ready in gap"}, in_ready, 1);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = f.data[63 - 8*i -: 8];
            chk({f.name, " in_ready"}, in_ready, 1);
            chk({f.name, " busy accum"}, busy, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        waited = 0;
        while (!res_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        exp_cks = exp_q.pop_front();
        exp_ok  = exp_ok_q.pop_front();
        chk({f.name, " res_valid"}, res_valid, 1);
        chk({f.name, " latency"}, cyc - t0, f.len + 1 + f.len * f.gap);
        chk({f.name, " checksum"}, checksum, exp_cks);
        chk({f.name, " sum_ok"}, sum_ok, exp_ok);
        chk({f.name, " in_ready done"}, in_ready, 0);
        held = checksum;
        for (int h = 0; h < f.hold; h++) begin
            start   = (h == 1);
            cfg_len = LEN_W'(4);
            @(negedge clk);
            chk({f.name, " hold res_valid"}, res_valid, 1);
            chk({f.name, " hold checksum"}, checksum, held);
            chk({f.name, " hold in_ready"}, in_ready, 0);
        end
        start     = 1'b0;
        cfg_len   = '0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({f.name, " res_valid cleared"}, res_valid, 0);
        chk({f.name, " busy cleared"}, busy, 0);
        chk({f.name, " back to idle"}, fsm_state, 0);
    endtask

    initial begin
        vec[0] = '{"even4",   4, 64'h1234ABCD_00000000, 0, 0, 16'h41FE, 1'b0};
        vec[1] = '{"carry",   4, 64'hFFFF0001_00000000, 0, 2, 16'hFFFE, 1'b0};
        vec[2] = '{"verify",  6, 64'h1234ABCD_41FE0000, 0, 0, 16'h0000, 1'b1};
        vec[3] = '{"odd3gap", 3, 64'h010203_0000000000, 2, 0, 16'hFBFD, 1'b0};
        vec[4] = '{"zero",    0, 64'h0,                 0, 5, 16'hFFFF, 1'b0};

        rst = 1'b1; start = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", in_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset checksum", checksum, 16'hFFFF);
        chk("reset sum_ok", sum_ok, 0);
        chk("reset state", fsm_state, 0);

        for (int v = 0; v < 5; v++) run_frame(vec[v]);

        // reset after 3 of 6 bytes: the partial frame must vanish
        @(negedge clk);
        start = 1'b1; cfg_len = LEN_W'(6);
        @(negedge clk);
        start = 1'b0; cfg_len = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h55 + 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst in_ready", in_ready, 0);
        chk("midrst res_valid", res_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst stays quiet", res_valid, 0);
        end
        run_frame(vec[0]);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/checksum_ctrl.md
# checksum_ctrl

Sequencing controller for the 16-bit one's-complement checksum datapath. It accepts a frame of bytes serially over a valid/ready handshake and pairs them big-endian into 16-bit words. It accumulates the words with end-around carry and presents the checksum plus a pass flag through a held result handshake. It replaces the wide parallel frame input so that arbitrary-length frames (e.g. 24-byte text payloads) can be checked from a byte stream.

## Interface
- LEN_W, 8, width of frame-length field; max frame = 2^LEN_W-1 bytes
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- start  in  1  begin a frame; sampled only in IDLE
- cfg_len  in  LEN_W  frame length in bytes, latched with start
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts a byte this cycle
- in_data  in  8  frame byte
- busy  out  1  high in every state except IDLE
- res_valid  out  1  result available, held until accepted
- res_ready  in  1  consumer accepts result
- checksum  out  16  ~sum (one's complement of accumulated sum)
- sum_ok  out  1  1 when accumulated sum == 16'hFFFF (frame with embedded checksum verifies)

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, res_valid=0. On start=1:
  - latch cfg_len into the remaining-byte counter;
  - clear sum and byte-phase.
  - Next state is ACCUM if cfg_len≠0, else DONE.
- ACCUM: in_ready=1. A byte transfers when in_valid && in_ready.
  - Phase 0 (high byte): store in hi_reg; phase←1.
  - Phase 1 (low byte): word={hi_reg,in_data}; sum←fold(sum+word); phase←0.
  - If the transferred byte is the last one (counter==1) and phase was 0 (odd length), add word={in_data,8'h00} instead.
  - Counter decrements per transfer; after the last byte, next state is DONE.
- fold(x): 17-bit add; result = x[15:0] + x[16]. A single fold is sufficient: the second carry cannot occur.
- DONE: res_valid=1, checksum=~sum, sum_ok=(sum==16'hFFFF). Both are stable while res_valid=1. On res_ready=1, next state is IDLE.
- start is ignored outside IDLE. in_data is ignored outside ACCUM.
- Zero-length frame: DONE with sum=0, checksum=16'hFFFF, sum_ok=0.
- No abort input. rst is the only way to cancel a frame.

## Timing
- Reset (sync, rst=1 at a rising edge): state=IDLE; sum=0, hi_reg=0, counter=0, phase=0; outputs in_ready=0, busy=0, res_valid=0, checksum=16'hFFFF, sum_ok=0.
- rst asserted mid-frame or in DONE: all state discarded at that edge; any partial frame is lost. The consumer must not see res_valid.
- start edge → ACCUM (in_ready=1) in the following cycle. One byte can transfer per cycle, so an N-byte frame with back-to-back in_valid takes N cycles in ACCUM.
- res_valid rises in the cycle after the last byte transfers. Latency from start is N+1 cycles plus any in_valid stalls.
- Result handshake completes on the edge where res_valid && res_ready. IDLE is reached the next cycle, and start is accepted there (1 idle cycle minimum between frames).
- in_valid stalls hold all state; phase is preserved across gaps.
- checksum/sum_ok are combinational from the sum register. They are only meaningful while res_valid=1.

## Test plan
- Even frame: len=4, bytes 12 34 AB CD back-to-back → res_valid at cycle 5 after start, checksum=16'h41FE, sum_ok=0.
- End-around carry: len=4, bytes FF FF 00 01 → sum=16'h0001, checksum=16'hFFFE.
- Verify path: len=6, bytes 12 34 AB CD 41 FE → sum=16'hFFFF, checksum=16'h0000, sum_ok=1.
- Odd length plus stalls: len=3, bytes 01 02 03 with in_valid gaps of 2 cycles → checksum=16'hFBFD. Result is unchanged by the stalls, and in_ready stays 1 throughout ACCUM.
- Zero length and backpressure: len=0 → DONE the next cycle with checksum=16'hFFFF, sum_ok=0. Hold res_ready=0 for 5 cycles → outputs stable. A start pulsed during DONE is ignored.
- Reset mid-frame: len=6, rst after 3 bytes → next cycle busy=0, in_ready=0, res_valid=0. A new len=4 frame (12 34 AB CD) then yields 16'h41FE.
